// File: rtl/vram_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// vram_access_arbiter_if
//   Bundles every requester handshake and every VRAM pin of the VRAM access
//   arbiter into one interface.
//
//   Requester side (driven by clients, read by the arbiter):
//     ppu_lock             PPU is in mode 3; CPU is locked out of VRAM
//     ppu_req / ppu_addr   PPU fetch request and address
//     dma_req / dma_addr   OAM DMA source read request and address
//     cpu_req / cpu_we / cpu_addr / cpu_wdata   CPU access
//   Arbiter responses:
//     ppu_grant, dma_grant  1-cycle pulse in the owner's address phase
//     ppu_rvld, dma_rvld    1-cycle pulse, rdata holds the read data
//     cpu_done              1-cycle pulse, CPU access complete
//     rdata                 registered read data shared by all requesters
//     busy                  arbiter is not idle
//   VRAM pins:
//     ma_out, md_out, md_oe, md_in, mcs, moe, mwr
//
//   Modports: slave = the arbiter, master = the client / pin side.
// ---------------------------------------------------------------------------
interface vram_access_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              ppu_lock;
    logic              ppu_req;
    logic [ADDR_W-1:0] ppu_addr;
    logic              ppu_grant;
    logic              ppu_rvld;

    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_grant;
    logic              dma_rvld;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_done;

    logic [DATA_W-1:0] rdata;
    logic              busy;

    logic [ADDR_W-1:0] ma_out;
    logic [DATA_W-1:0] md_out;
    logic              md_oe;
    logic [DATA_W-1:0] md_in;
    logic              mcs;
    logic              moe;
    logic              mwr;

    modport slave (
        input  ppu_lock, ppu_req, ppu_addr,
        input  dma_req, dma_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  md_in,
        output ppu_grant, ppu_rvld, dma_grant, dma_rvld, cpu_done,
        output rdata, busy,
        output ma_out, md_out, md_oe, mcs, moe, mwr
    );

    modport master (
        output ppu_lock, ppu_req, ppu_addr,
        output dma_req, dma_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output md_in,
        input  ppu_grant, ppu_rvld, dma_grant, dma_rvld, cpu_done,
        input  rdata, busy,
        input  ma_out, md_out, md_oe, mcs, moe, mwr
    );
endinterface

// File: rtl/vram_access_arbiter.sv
// ---------------------------------------------------------------------------
// vram_access_arbiter
//   Owns the VRAM bus and shares it between the PPU fetcher, the OAM DMA
//   engine and the CPU with fixed priority PPU > DMA > CPU. Each access is an
//   address phase, DATA_CYCLES data phases and a response cycle. While the
//   PPU holds ppu_lock the CPU never reaches the bus: reads answer 0xFF and
//   writes are dropped, both acknowledged with cpu_done.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    vram_access_arbiter_if.slave (requesters + VRAM pins)
//
//   Parameters:
//     ADDR_W       VRAM address width
//     DATA_W       VRAM data width
//     DATA_CYCLES  data-phase cycles per access (1..3)
// ---------------------------------------------------------------------------
module vram_access_arbiter #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 8,
    parameter int DATA_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    vram_access_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_PPU, OWN_DMA, OWN_CPU} owner_t;

    localparam logic [1:0] CNT_LAST = 2'(DATA_CYCLES - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] ma_q, ma_d;
    logic [DATA_W-1:0] md_q, md_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              lock_done_q, lock_done_d;

    owner_t pick;
    logic   arb_edge;
    logic   lock_hit;

    // Priority pick. A CPU request only competes for the bus when the PPU
    // does not hold the lock; a locked CPU request is answered separately.
    always_comb begin
        pick = OWN_NONE;
        if (bus.ppu_req) begin
            pick = OWN_PPU;
        end else if (bus.dma_req) begin
            pick = OWN_DMA;
        end else if (bus.cpu_req && !bus.ppu_lock) begin
            pick = OWN_CPU;
        end
    end

    assign arb_edge = (state_q == S_IDLE) || (state_q == S_RESP);

    // Locked-out answers are only issued from IDLE so cpu_done never shares
    // a cycle with another owner's completion. From RESP the arbiter falls
    // back to IDLE and answers one cycle later.
    assign lock_hit = (state_q == S_IDLE) && (pick == OWN_NONE) &&
                      bus.cpu_req && bus.ppu_lock;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            we_q        <= 1'b0;
            cnt_q       <= 2'd0;
            ma_q        <= '0;
            md_q        <= '0;
            rdata_q     <= '1;
            lock_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            ma_q        <= ma_d;
            md_q        <= md_d;
            rdata_q     <= rdata_d;
            lock_done_q <= lock_done_d;
        end
    end

    // Next-state and datapath loads
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        ma_d        = ma_q;
        md_d        = md_q;
        rdata_d     = rdata_q;
        lock_done_d = lock_hit;

        case (state_q)
            S_IDLE, S_RESP: begin
                if (pick != OWN_NONE) begin
                    state_d = S_ADDR;
                    owner_d = pick;
                    case (pick)
                        OWN_PPU: begin
                            ma_d = bus.ppu_addr;
                            we_d = 1'b0;
                        end
                        OWN_DMA: begin
                            ma_d = bus.dma_addr;
                            we_d = 1'b0;
                        end
                        default: begin
                            ma_d = bus.cpu_addr;
                            we_d = bus.cpu_we;
                            // md_out keeps its old value across reads
                            if (bus.cpu_we) begin
                                md_d = bus.cpu_wdata;
                            end
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                state_d = S_DATA;
                cnt_d   = 2'd0;
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                    if (!we_q) begin
                        rdata_d = bus.md_in;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (lock_hit && !bus.cpu_we) begin
            rdata_d = '1;
        end
    end

    // Output decode
    logic mcs, moe, mwr, md_oe;
    logic ppu_grant, dma_grant, ppu_rvld, dma_rvld, cpu_done, busy;

    always_comb begin
        mcs       = (state_q == S_ADDR) || (state_q == S_DATA);
        moe       = mcs && !we_q;
        md_oe     = mcs && we_q;
        mwr       = (state_q == S_DATA) && we_q;
        ppu_grant = (state_q == S_ADDR) && (owner_q == OWN_PPU);
        dma_grant = (state_q == S_ADDR) && (owner_q == OWN_DMA);
        ppu_rvld  = (state_q == S_RESP) && (owner_q == OWN_PPU);
        dma_rvld  = (state_q == S_RESP) && (owner_q == OWN_DMA);
        cpu_done  = ((state_q == S_RESP) && (owner_q == OWN_CPU)) || lock_done_q;
        busy      = (state_q != S_IDLE);
    end

    assign bus.mcs       = mcs;
    assign bus.moe       = moe;
    assign bus.md_oe     = md_oe;
    assign bus.mwr       = mwr;
    assign bus.ppu_grant = ppu_grant;
    assign bus.dma_grant = dma_grant;
    assign bus.ppu_rvld  = ppu_rvld;
    assign bus.dma_rvld  = dma_rvld;
    assign bus.cpu_done  = cpu_done;
    assign bus.busy      = busy;
    assign bus.ma_out    = ma_q;
    assign bus.md_out    = md_q;
    assign bus.rdata     = rdata_q;

endmodule
